// File: rtl/iir_coeff_loader_if.sv
// Coefficient write bus between the host register bank and the loader.
// A word transfers on any cycle where wr_valid and wr_ready are both high.
interface iir_coeff_loader_if #(
  parameter int ADDR_WIDTH  = 3,
  parameter int COEFF_WIDTH = 14
);
  logic                   wr_valid;
  logic                   wr_ready;
  logic [ADDR_WIDTH-1:0]  wr_addr;
  logic [COEFF_WIDTH-1:0] wr_data;
  logic                   wr_last;

  modport master (output wr_valid, wr_addr, wr_data, wr_last, input wr_ready);
  modport slave  (input wr_valid, wr_addr, wr_data, wr_last, output wr_ready);
endinterface

// File: rtl/iir_coeff_loader.sv
// IIR coefficient loader: collects coefficient writes into shadow registers and
// commits the whole set to the active registers on a sample boundary, then holds
// the filter datapath in reset while its delay lines flush.
//
// state  | meaning
// IDLE   | no set in progress, waiting for the first write of a set
// LOAD   | set in progress, accepting further writes until wr_last
// ARM    | complete set in shadow, waiting for a sample_strobe
// COMMIT | shadow copied to active at the end of this cycle, filter_rst high
// FLUSH  | filter_rst held for the remaining FLUSH_CYCLES-1 cycles
module iir_coeff_loader #(
  parameter int M            = 2,
  parameter int COEFF_WIDTH  = 14,
  parameter int FLUSH_CYCLES = 4,
  parameter int ADDR_WIDTH   = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  iir_coeff_loader_if.slave            wr,
  input  logic                         sample_strobe,
  output logic [(M+1)*COEFF_WIDTH-1:0] packed_b_coeffs,
  output logic [M*COEFF_WIDTH-1:0]     packed_a_coeffs,
  output logic                         filter_rst,
  output logic                         busy,
  output logic                         err
);

  typedef enum logic [2:0] {IDLE, LOAD, ARM, COMMIT, FLUSH} state_t;

  localparam int NUM_COEFFS = 2*M + 1;
  localparam logic [ADDR_WIDTH-1:0] MAX_ADDR = ADDR_WIDTH'(2*M);
  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  state_t                 state_q, state_nxt;
  logic [COEFF_WIDTH-1:0] shadow_q [NUM_COEFFS];
  logic [COEFF_WIDTH-1:0] active_q [NUM_COEFFS];
  logic                   err_q, err_nxt;
  logic [CNT_W-1:0]       flush_cnt_q;
  logic                   ready;
  logic                   bad_addr;
  logic                   shadow_we;
  logic                   commit;
  logic                   flush_rst;
  logic                   cnt_load;
  logic                   cnt_dec;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_nxt;
  end

  // Next-state and control decode
  always_comb begin
    state_nxt = state_q;
    ready     = 1'b0;
    bad_addr  = 1'b0;
    shadow_we = 1'b0;
    err_nxt   = err_q;
    commit    = 1'b0;
    flush_rst = 1'b0;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (wr.wr_valid) begin
          // A new set starts here, so any error from the previous set is forgotten.
          bad_addr  = (wr.wr_addr > MAX_ADDR);
          shadow_we = ~bad_addr;
          err_nxt   = bad_addr;
          if (wr.wr_last) state_nxt = bad_addr ? IDLE : ARM;
          else            state_nxt = LOAD;
        end
      end
      LOAD: begin
        ready = 1'b1;
        if (wr.wr_valid) begin
          bad_addr  = (wr.wr_addr > MAX_ADDR);
          shadow_we = ~bad_addr;
          err_nxt   = err_q | bad_addr;
          if (wr.wr_last) state_nxt = (err_q | bad_addr) ? IDLE : ARM;
        end
      end
      ARM: begin
        if (sample_strobe) state_nxt = COMMIT;
      end
      COMMIT: begin
        commit    = 1'b1;
        flush_rst = 1'b1;
        if (FLUSH_CYCLES > 1) begin
          cnt_load  = 1'b1;
          state_nxt = FLUSH;
        end else begin
          state_nxt = IDLE;
        end
      end
      FLUSH: begin
        flush_rst = 1'b1;
        if (flush_cnt_q == CNT_W'(1)) state_nxt = IDLE;
        else                          cnt_dec   = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Flush timer: counts down the filter_rst cycles remaining after COMMIT
  always_ff @(posedge clk) begin
    if (rst)           flush_cnt_q <= '0;
    else if (cnt_load) flush_cnt_q <= CNT_W'(FLUSH_CYCLES - 1);
    else if (cnt_dec)  flush_cnt_q <= flush_cnt_q - CNT_W'(1);
  end

  // Sticky per-set error flag
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_nxt;
  end

  // Shadow registers: last write to an address within a set wins
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_COEFFS; i++) shadow_q[i] <= '0;
    end else if (shadow_we) begin
      shadow_q[wr.wr_addr] <= wr.wr_data;
    end
  end

  // Active registers: whole set replaced at once, never partially
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_COEFFS; i++) active_q[i] <= '0;
    end else if (commit) begin
      for (int i = 0; i < NUM_COEFFS; i++) active_q[i] <= shadow_q[i];
    end
  end

  for (genvar gi = 0; gi <= M; gi++) begin : g_pack_b
    assign packed_b_coeffs[gi*COEFF_WIDTH +: COEFF_WIDTH] = active_q[gi];
  end

  for (genvar gi = 1; gi <= M; gi++) begin : g_pack_a
    assign packed_a_coeffs[(gi-1)*COEFF_WIDTH +: COEFF_WIDTH] = active_q[M+gi];
  end

  assign wr.wr_ready = ready;
  // The filter is also held in reset for as long as the loader itself is.
  assign filter_rst  = rst | flush_rst;
  assign busy        = (state_q != IDLE);
  assign err         = err_q;

endmodule

// File: tb/tb_iir_coeff_loader.sv
// Testbench for iir_coeff_loader (M=2, COEFF_WIDTH=14, FLUSH_CYCLES=4).
// A transaction-level model tracks shadow/active coefficients, the armed set and
// the number of filter_rst cycles still owed; outputs are compared every cycle.
module tb_iir_coeff_loader;
  localparam int M     = 2;
  localparam int W     = 14;
  localparam int FLUSH = 4;
  localparam int AW    = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sample_strobe = 1'b0;
  logic [(M+1)*W-1:0] packed_b;
  logic [M*W-1:0]     packed_a;
  logic filter_rst, busy, err;

  iir_coeff_loader_if #(.ADDR_WIDTH(AW), .COEFF_WIDTH(W)) bus ();

  iir_coeff_loader #(.M(M), .COEFF_WIDTH(W), .FLUSH_CYCLES(FLUSH), .ADDR_WIDTH(AW)) dut (
    .clk             (clk),
    .rst             (rst),
    .wr              (bus),
    .sample_strobe   (sample_strobe),
    .packed_b_coeffs (packed_b),
    .packed_a_coeffs (packed_a),
    .filter_rst      (filter_rst),
    .busy            (busy),
    .err             (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;
  int frst_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: what has been written, what is live, and what the loader owes the filter
  logic [W-1:0] m_shadow [5];
  logic [W-1:0] m_active [5];
  bit m_err, m_in_set, m_armed;
  int m_rst_left;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 5; i++) begin
        m_shadow[i] = '0;
        m_active[i] = '0;
      end
      m_err = 0; m_in_set = 0; m_armed = 0; m_rst_left = 0;
    end else if (m_rst_left > 0) begin
      if (m_rst_left == FLUSH)
        for (int i = 0; i < 5; i++) m_active[i] = m_shadow[i];
      m_rst_left--;
    end else if (m_armed) begin
      if (sample_strobe) begin
        m_armed = 0;
        m_rst_left = FLUSH;
      end
    end else if (bus.wr_valid) begin
      if (!m_in_set) m_err = 0;
      if (bus.wr_addr > 3'd4) m_err = 1;
      else m_shadow[bus.wr_addr] = bus.wr_data;
      if (bus.wr_last) begin
        m_in_set = 0;
        m_armed = !m_err;
      end else begin
        m_in_set = 1;
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("wr_ready", 64'(bus.wr_ready), 64'(!m_armed && m_rst_left == 0));
      check("busy", 64'(busy), 64'(m_armed || m_rst_left > 0 || m_in_set));
      check("err", 64'(err), 64'(m_err));
      check("filter_rst", 64'(filter_rst), 64'(rst || m_rst_left > 0));
      check("packed_b", 64'(packed_b), 64'({m_active[2], m_active[1], m_active[0]}));
      check("packed_a", 64'(packed_a), 64'({m_active[4], m_active[3]}));
    end
  end

  always @(negedge clk) if (filter_rst && !rst) frst_cnt++;

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic write(input logic [AW-1:0] a, input logic [W-1:0] d, input logic last);
    bit r;
    int n;
    bus.wr_valid = 1'b1; bus.wr_addr = a; bus.wr_data = d; bus.wr_last = last;
    r = 0; n = 0;
    while (!r && n < 50) begin
      @(negedge clk); r = bus.wr_ready;
      @(posedge clk); #1;
      n++;
    end
    if (!r) begin failures++; checks++; $display("FAIL write_timeout: got no handshake expected handshake"); end
    bus.wr_valid = 1'b0; bus.wr_last = 1'b0;
  endtask

  task automatic strobe();
    sample_strobe = 1'b1;
    @(posedge clk); #1;
    sample_strobe = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    bit done = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      if (!busy) done = 1;
      n++;
    end
    if (!done) begin failures++; checks++; $display("FAIL wait_idle_timeout: got busy expected idle"); end
    @(posedge clk); #1;
  endtask

  task automatic pulse_rst_and_check(input string tag);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_ready"}, 64'(bus.wr_ready), 64'd1);
    check({tag, "_b"}, 64'(packed_b), 64'd0);
    check({tag, "_a"}, 64'(packed_a), 64'd0);
    check({tag, "_frst"}, 64'(filter_rst), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit r;
    bus.wr_valid = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.wr_last = 1'b0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_ready", 64'(bus.wr_ready), 64'd1);
    check("reset_frst", 64'(filter_rst), 64'd0);
    check("reset_b", 64'(packed_b), 64'd0);
    @(posedge clk); #1;

    // 1: full load, commit three cycles after wr_last
    write(3'd0, 14'h1000, 0);
    write(3'd1, 14'h0800, 0);
    write(3'd2, 14'h0400, 0);
    write(3'd3, 14'h3C00, 0);
    write(3'd4, 14'h0200, 1);
    frst_cnt = 0;
    idle(2);
    strobe();
    wait_idle();
    check("t1_frst_cycles", 64'(frst_cnt), 64'd4);
    check("t1_b", 64'(packed_b), 64'({14'h0400, 14'h0800, 14'h1000}));
    check("t1_a", 64'(packed_a), 64'({14'h0200, 14'h3C00}));

    // 2: strobe coincident with wr_last handshake is ignored
    write(3'd0, 14'h0111, 0);
    sample_strobe = 1'b1;
    write(3'd1, 14'h0222, 1);
    sample_strobe = 1'b0;
    frst_cnt = 0;
    idle(3);
    @(negedge clk);
    check("t2_still_armed", 64'(busy), 64'd1);
    check("t2_no_flush", 64'(frst_cnt), 64'd0);
    check("t2_b_held", 64'(packed_b), 64'({14'h0400, 14'h0800, 14'h1000}));
    @(posedge clk); #1;
    strobe();
    wait_idle();
    check("t2_frst_cycles", 64'(frst_cnt), 64'd4);
    check("t2_b", 64'(packed_b), 64'({14'h0400, 14'h0222, 14'h0111}));

    // 4: partial reload of b1 only
    write(3'd1, 14'h0123, 1);
    strobe();
    wait_idle();
    check("t4_b", 64'(packed_b), 64'({14'h0400, 14'h0123, 14'h0111}));
    check("t4_a", 64'(packed_a), 64'({14'h0200, 14'h3C00}));

    // 3: bad address aborts the set
    write(3'd0, 14'h1FFF, 0);
    write(3'd7, 14'h2AAA, 0);
    @(negedge clk);
    check("t3_err_set", 64'(err), 64'd1);
    @(posedge clk); #1;
    write(3'd1, 14'h0333, 1);
    frst_cnt = 0;
    @(negedge clk);
    check("t3_aborted_idle", 64'(busy), 64'd0);
    check("t3_err_sticky", 64'(err), 64'd1);
    @(posedge clk); #1;
    strobe();
    idle(6);
    check("t3_no_flush", 64'(frst_cnt), 64'd0);
    check("t3_b_unchanged", 64'(packed_b), 64'({14'h0400, 14'h0123, 14'h0111}));

    // 5: reset during FLUSH, then during ARM
    write(3'd0, 14'h0AAA, 1);
    strobe();
    idle(1);
    pulse_rst_and_check("t5_flush");
    write(3'd3, 14'h0777, 1);
    pulse_rst_and_check("t5_arm");

    // 6: write held through ARM/COMMIT/FLUSH is taken on the first IDLE cycle
    write(3'd2, 14'h0999, 1);
    bus.wr_valid = 1'b1; bus.wr_addr = 3'd0; bus.wr_data = 14'h0055; bus.wr_last = 1'b1;
    sample_strobe = 1'b1;
    n = 0; r = 0;
    while (!r && n < 30) begin
      @(negedge clk); r = bus.wr_ready;
      @(posedge clk); #1;
      sample_strobe = 1'b0;
      if (!r) n++;
    end
    bus.wr_valid = 1'b0; bus.wr_last = 1'b0;
    check("t6_accept_delay", 64'(n), 64'd5);
    check("t6_b_first", 64'(packed_b), 64'({14'h0999, 14'h0000, 14'h0000}));
    strobe();
    wait_idle();
    check("t6_b_second", 64'(packed_b), 64'({14'h0999, 14'h0000, 14'h0055}));

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
